// File: rtl/ap_ctrl_perf_pkg.sv
// Shared types and helpers for the ap_ctrl_hs performance monitor.
package ap_ctrl_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_HOLD
  } chan_state_e;

  typedef enum logic [2:0] {
    FLD_TXN      = 3'd0,
    FLD_LAST_LAT = 3'd1,
    FLD_MIN_LAT  = 3'd2,
    FLD_MAX_LAT  = 3'd3,
    FLD_BUSY     = 3'd4,
    FLD_STALL    = 3'd5,
    FLD_LAST_II  = 3'd6,
    FLD_RSVD     = 3'd7
  } rd_field_e;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/ap_ctrl_perf_monitor_chan.sv
// Per-channel ap_ctrl_hs tracker: handshake FSM plus saturating counters.
// Min/max latency registers exist only when AP_CTRL_PERF_MINMAX_EN is defined.
module ap_ctrl_chan_tracker
  import ap_ctrl_perf_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             done,
  input  logic             cont,
  input  logic             finish,
  input  logic             clear,
  output logic [CNT_W-1:0] txn,
  output logic [CNT_W-1:0] last_lat,
`ifdef AP_CTRL_PERF_MINMAX_EN
  output logic [CNT_W-1:0] min_lat,
  output logic [CNT_W-1:0] max_lat,
`endif
  output logic [CNT_W-1:0] busy_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] last_ii,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] MAX = '1;

  chan_state_e      state;
  logic [CNT_W-1:0] lat_tmr;
  logic [CNT_W-1:0] ii_tmr;
  logic [CNT_W-1:0] lat_val;
  logic             seen_start;
  logic             start_acc;
  logic             complete;
  logic             ovf_hit;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), 64'(MAX)));
  endfunction

  always_comb begin
    start_acc = (state == ST_IDLE) && start;
    complete  = done && (start_acc || (state == ST_BUSY));
    lat_val   = start_acc ? '0 : lat_tmr;
    ovf_hit   = !finish && ((complete && (txn == MAX)) ||
                            ((state == ST_BUSY) && (busy_cnt == MAX)) ||
                            ((state == ST_HOLD) && (stall_cnt == MAX)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      lat_tmr    <= '0;
      ii_tmr     <= '0;
      seen_start <= 1'b0;
      txn        <= '0;
      last_lat   <= '0;
`ifdef AP_CTRL_PERF_MINMAX_EN
      min_lat    <= '1;
      max_lat    <= '0;
`endif
      busy_cnt   <= '0;
      stall_cnt  <= '0;
      last_ii    <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= done ? (cont ? ST_IDLE : ST_HOLD) : ST_BUSY;
        ST_BUSY: if (done)  state <= cont ? ST_IDLE : ST_HOLD;
        ST_HOLD: if (cont)  state <= ST_IDLE;
        default:            state <= ST_IDLE;
      endcase

      // Elapsed-time trackers run regardless of finish/clear so that a
      // transaction spanning a freeze is still measured correctly.
      if (start_acc) begin
        lat_tmr    <= CNT_W'(1);
        ii_tmr     <= CNT_W'(1);
        seen_start <= 1'b1;
      end else begin
        ii_tmr <= inc(ii_tmr);
        if (state == ST_BUSY) lat_tmr <= inc(lat_tmr);
      end

      if (clear) begin
        txn       <= '0;
        last_lat  <= '0;
`ifdef AP_CTRL_PERF_MINMAX_EN
        min_lat   <= '1;
        max_lat   <= '0;
`endif
        busy_cnt  <= '0;
        stall_cnt <= '0;
        last_ii   <= '0;
        ovf       <= 1'b0;
      end else if (!finish) begin
        if (state == ST_BUSY) busy_cnt  <= inc(busy_cnt);
        if (state == ST_HOLD) stall_cnt <= inc(stall_cnt);
        if (complete) begin
          txn      <= inc(txn);
          last_lat <= lat_val;
`ifdef AP_CTRL_PERF_MINMAX_EN
          if (lat_val < min_lat) min_lat <= lat_val;
          if (lat_val > max_lat) max_lat <= lat_val;
`endif
        end
        if (start_acc && seen_start) last_ii <= ii_tmr;
        if (ovf_hit) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl_hs performance monitor with registered readout port.
// Define AP_CTRL_PERF_MINMAX_EN to enable min/max latency tracking.
module ap_ctrl_perf_monitor
  import ap_ctrl_perf_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [3:0]        rd_ch,
  input  logic [2:0]        rd_field,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic [NUM_CH-1:0] ovf
);

  localparam int unsigned MAX_CH = 16;

  // Arrays are padded to the full rd_ch range so readout indexing never runs out of bounds.
  logic [CNT_W-1:0] txn_a   [MAX_CH];
  logic [CNT_W-1:0] last_a  [MAX_CH];
`ifdef AP_CTRL_PERF_MINMAX_EN
  logic [CNT_W-1:0] min_a   [MAX_CH];
  logic [CNT_W-1:0] max_a   [MAX_CH];
`endif
  logic [CNT_W-1:0] busy_a  [MAX_CH];
  logic [CNT_W-1:0] stall_a [MAX_CH];
  logic [CNT_W-1:0] ii_a    [MAX_CH];
  logic [CNT_W-1:0] sel_data;
  logic             sel_err;

  for (genvar g = 0; g < MAX_CH; g++) begin : g_ch
    if (g < NUM_CH) begin : g_trk
      ap_ctrl_chan_tracker #(.CNT_W(CNT_W)) u_trk (
        .clock     (clock),
        .reset     (reset),
        .start     (ap_start[g]),
        .done      (ap_done[g]),
        .cont      (ap_continue[g]),
        .finish    (finish),
        .clear     (clear),
        .txn       (txn_a[g]),
        .last_lat  (last_a[g]),
`ifdef AP_CTRL_PERF_MINMAX_EN
        .min_lat   (min_a[g]),
        .max_lat   (max_a[g]),
`endif
        .busy_cnt  (busy_a[g]),
        .stall_cnt (stall_a[g]),
        .last_ii   (ii_a[g]),
        .ovf       (ovf[g])
      );
    end else begin : g_pad
      assign txn_a[g]   = '0;
      assign last_a[g]  = '0;
`ifdef AP_CTRL_PERF_MINMAX_EN
      assign min_a[g]   = '0;
      assign max_a[g]   = '0;
`endif
      assign busy_a[g]  = '0;
      assign stall_a[g] = '0;
      assign ii_a[g]    = '0;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_err  = 1'b0;
    case (rd_field_e'(rd_field))
      FLD_TXN:      sel_data = txn_a[rd_ch];
      FLD_LAST_LAT: sel_data = last_a[rd_ch];
`ifdef AP_CTRL_PERF_MINMAX_EN
      FLD_MIN_LAT:  sel_data = min_a[rd_ch];
      FLD_MAX_LAT:  sel_data = max_a[rd_ch];
`endif
      FLD_BUSY:     sel_data = busy_a[rd_ch];
      FLD_STALL:    sel_data = stall_a[rd_ch];
      FLD_LAST_II:  sel_data = ii_a[rd_ch];
      default:      sel_err  = 1'b1;
    endcase
    if (32'(rd_ch) >= NUM_CH) begin
      sel_data = '0;
      sel_err  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= rd_req ? sel_data : '0;
      rd_err   <= rd_req & sel_err;
    end
  end

endmodule
